alu_op_sequencer: RTL and testbench

- Micro-sequencer and register file that wraps the 4-bit ALU.
- It accepts 12-bit micro-instructions through a valid/ready handshake, reads operands from a 4-entry x 4-bit register file, and drives the ALU's A/B/OP inputs.
- It waits ALU_LAT cycles, then writes the ALU Result back to the destination register.
- It is the stage directly upstream of the ALU that feeds it, and it also consumes the ALU's Result.

---
 rtl/alu_op_sequencer_pkg.sv | 28 ++
 rtl/alu_regfile.sv | 37 +++
 rtl/alu_op_sequencer.sv | 168 ++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_op_sequencer_pkg.sv
// Shared opcodes, FSM states and instruction field positions
// for the ALU micro-sequencer.
package alu_op_sequencer_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_WB   = 2'd2
   } state_e;

   localparam int unsigned F_FORM = 11;
   localparam int unsigned F_OP   = 8;
   localparam int unsigned F_RD   = 6;
   localparam int unsigned F_RS1  = 4;
   localparam int unsigned F_RS2  = 2;
   localparam int unsigned F_IMM  = 0;

   function automatic logic op_legal(input logic [2:0] op);
      return op <= OP_XOR;
   endfunction

endpackage

// File: rtl/alu_regfile.sv
// Small register file: one write port, two operand read ports
// and a debug read port, all reads combinational.
module alu_regfile #(
   parameter int DW    = 4,
   parameter int NREGS = 4,
   localparam int AW   = $clog2(NREGS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic [AW-1:0] raddr_a_i,
   input  logic [AW-1:0] raddr_b_i,
   output logic [DW-1:0] rdata_a_o,
   output logic [DW-1:0] rdata_b_o,
   input  logic [AW-1:0] dbg_sel_i,
   output logic [DW-1:0] dbg_data_o
);

   logic [DW-1:0] rf_q [NREGS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            rf_q[i] <= '0;
         end
      end else if (we_i) begin
         rf_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_a_o  = rf_q[raddr_a_i];
   assign rdata_b_o  = rf_q[raddr_b_i];
   assign dbg_data_o = rf_q[dbg_sel_i];

endmodule

// File: rtl/alu_op_sequencer.sv
// Micro-sequencer feeding the 4-bit ALU: accepts instructions,
// drives operands for ALU_LAT cycles, then writes the result back.
module alu_op_sequencer
   import alu_op_sequencer_pkg::*;
#(
   parameter int DW      = 4,
   parameter int NREGS   = 4,
   parameter int ALU_LAT = 1,
   localparam int AW     = $clog2(NREGS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          instr_valid,
   output logic          instr_ready,
   input  logic [11:0]   instr,
   output logic [DW-1:0] alu_a,
   output logic [DW-1:0] alu_b,
   output logic [2:0]    alu_op,
   input  logic [DW-1:0] alu_result,
   output logic          wb_valid,
   output logic [AW-1:0] wb_rd,
   output logic [DW-1:0] wb_data,
   output logic          illegal,
   input  logic [AW-1:0] dbg_sel,
   output logic [DW-1:0] dbg_data
);

   localparam logic [2:0] LAT_M1 = 3'(ALU_LAT - 1);

   state_e        state_q, state_d;
   logic [2:0]    cnt_q, cnt_d;
   logic [AW-1:0] rd_q, rd_d;
   logic [DW-1:0] alu_a_q, alu_a_d;
   logic [DW-1:0] alu_b_q, alu_b_d;
   logic [2:0]    alu_op_q, alu_op_d;
   logic          wb_valid_q, wb_valid_d;
   logic [AW-1:0] wb_rd_q, wb_rd_d;
   logic [DW-1:0] wb_data_q, wb_data_d;
   logic          illegal_q, illegal_d;

   logic          rf_we;
   logic [AW-1:0] rf_waddr;
   logic [DW-1:0] rf_wdata;
   logic [DW-1:0] rs1_data, rs2_data;

   logic          is_li;
   logic [2:0]    op_f;
   logic [AW-1:0] rd_f, rs1_f, rs2_f;
   logic [DW-1:0] imm_f;

   assign is_li = instr[F_FORM];
   assign op_f  = instr[F_OP +: 3];
   assign rd_f  = instr[F_RD +: AW];
   assign rs1_f = instr[F_RS1 +: AW];
   assign rs2_f = instr[F_RS2 +: AW];
   assign imm_f = instr[F_IMM +: DW];

   alu_regfile #(
      .DW    (DW),
      .NREGS (NREGS)
   ) u_rf (
      .clk        (clk),
      .rst_n      (rst_n),
      .we_i       (rf_we),
      .waddr_i    (rf_waddr),
      .wdata_i    (rf_wdata),
      .raddr_a_i  (rs1_f),
      .raddr_b_i  (rs2_f),
      .rdata_a_o  (rs1_data),
      .rdata_b_o  (rs2_data),
      .dbg_sel_i  (dbg_sel),
      .dbg_data_o (dbg_data)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rd_d       = rd_q;
      alu_a_d    = alu_a_q;
      alu_b_d    = alu_b_q;
      alu_op_d   = alu_op_q;
      wb_valid_d = 1'b0;
      wb_rd_d    = wb_rd_q;
      wb_data_d  = wb_data_q;
      illegal_d  = 1'b0;
      rf_we      = 1'b0;
      rf_waddr   = rd_q;
      rf_wdata   = alu_result;
      unique case (state_q)
         S_IDLE: begin
            if (instr_valid) begin
               if (is_li) begin
                  rf_we      = 1'b1;
                  rf_waddr   = rd_f;
                  rf_wdata   = imm_f;
                  wb_valid_d = 1'b1;
                  wb_rd_d    = rd_f;
                  wb_data_d  = imm_f;
                  state_d    = S_WB;
               end else if (!op_legal(op_f)) begin
                  illegal_d = 1'b1;
               end else begin
                  // operands sampled now, so rd==rs reads the old value
                  alu_a_d  = rs1_data;
                  alu_b_d  = rs2_data;
                  alu_op_d = op_f;
                  rd_d     = rd_f;
                  cnt_d    = LAT_M1;
                  state_d  = S_EXEC;
               end
            end
         end
         S_EXEC: begin
            if (cnt_q != 3'd0) begin
               cnt_d = cnt_q - 3'd1;
            end else begin
               rf_we      = 1'b1;
               wb_valid_d = 1'b1;
               wb_rd_d    = rd_q;
               wb_data_d  = alu_result;
               state_d    = S_WB;
            end
         end
         S_WB: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         rd_q       <= '0;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_op_q   <= '0;
         wb_valid_q <= 1'b0;
         wb_rd_q    <= '0;
         wb_data_q  <= '0;
         illegal_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rd_q       <= rd_d;
         alu_a_q    <= alu_a_d;
         alu_b_q    <= alu_b_d;
         alu_op_q   <= alu_op_d;
         wb_valid_q <= wb_valid_d;
         wb_rd_q    <= wb_rd_d;
         wb_data_q  <= wb_data_d;
         illegal_q  <= illegal_d;
      end
   end

   assign instr_ready = (state_q == S_IDLE);
   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign alu_op      = alu_op_q;
   assign wb_valid    = wb_valid_q;
   assign wb_rd       = wb_rd_q;
   assign wb_data     = wb_data_q;
   assign illegal     = illegal_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench: one sequencer with ALU_LAT=1, one with ALU_LAT=3,
// each closed around a behavioural 4-bit ALU.
module tb_alu_op_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   function automatic logic [3:0] alu_f(input logic [3:0] a,
                                        input logic [3:0] b,
                                        input logic [2:0] op);
      case (op)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a ^ b;
         default: return 4'd0;
      endcase
   endfunction

   // DUT 1: ALU_LAT = 1
   logic        rst_n1 = 1'b0, valid1 = 1'b0, ready1;
   logic [11:0] instr1 = '0;
   logic [3:0]  alu_a1, alu_b1, res1, wb_data1, dbg_data1;
   logic [2:0]  alu_op1;
   logic        wb_valid1, illegal1;
   logic [1:0]  wb_rd1, dbg_sel1 = '0;

   assign res1 = alu_f(alu_a1, alu_b1, alu_op1);

   alu_op_sequencer #(.DW(4), .NREGS(4), .ALU_LAT(1)) u_dut1 (
      .clk         (clk),
      .rst_n       (rst_n1),
      .instr_valid (valid1),
      .instr_ready (ready1),
      .instr       (instr1),
      .alu_a       (alu_a1),
      .alu_b       (alu_b1),
      .alu_op      (alu_op1),
      .alu_result  (res1),
      .wb_valid    (wb_valid1),
      .wb_rd       (wb_rd1),
      .wb_data     (wb_data1),
      .illegal     (illegal1),
      .dbg_sel     (dbg_sel1),
      .dbg_data    (dbg_data1)
   );

   // DUT 3: ALU_LAT = 3
   logic        rst_n3 = 1'b0, valid3 = 1'b0, ready3;
   logic [11:0] instr3 = '0;
   logic [3:0]  alu_a3, alu_b3, res3, wb_data3, dbg_data3;
   logic [2:0]  alu_op3;
   logic        wb_valid3, illegal3;
   logic [1:0]  wb_rd3, dbg_sel3 = '0;

   assign res3 = alu_f(alu_a3, alu_b3, alu_op3);

   alu_op_sequencer #(.DW(4), .NREGS(4), .ALU_LAT(3)) u_dut3 (
      .clk         (clk),
      .rst_n       (rst_n3),
      .instr_valid (valid3),
      .instr_ready (ready3),
      .instr       (instr3),
      .alu_a       (alu_a3),
      .alu_b       (alu_b3),
      .alu_op      (alu_op3),
      .alu_result  (res3),
      .wb_valid    (wb_valid3),
      .wb_rd       (wb_rd3),
      .wb_data     (wb_data3),
      .illegal     (illegal3),
      .dbg_sel     (dbg_sel3),
      .dbg_data    (dbg_data3)
   );

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [11:0] li(input logic [1:0] rd,
                                      input logic [3:0] imm);
      return {1'b1, 3'b000, rd, 2'b00, imm};
   endfunction

   function automatic logic [11:0] ai(input logic [2:0] op,
                                      input logic [1:0] rd,
                                      input logic [1:0] rs1,
                                      input logic [1:0] rs2);
      return {1'b0, op, rd, rs1, rs2, 2'b00};
   endfunction

   // all tasks start and end on a falling edge
   task automatic rf1(input logic [1:0] idx, input logic [3:0] exp);
      dbg_sel1 = idx;
      #1;
      check($sformatf("rf1[%0d]", idx), dbg_data1, exp);
   endtask

   task automatic rf3(input logic [1:0] idx, input logic [3:0] exp);
      dbg_sel3 = idx;
      #1;
      check($sformatf("rf3[%0d]", idx), dbg_data3, exp);
   endtask

   task automatic do_li1(input logic [1:0] rd, input logic [3:0] imm);
      check("li_ready", ready1, 1'b1);
      valid1 = 1'b1;
      instr1 = li(rd, imm);
      @(posedge clk);
      @(negedge clk);
      valid1 = 1'b0;
      check("li_wbv", wb_valid1, 1'b1);
      check("li_wbrd", wb_rd1, rd);
      check("li_wbdata", wb_data1, imm);
      check("li_busy", ready1, 1'b0);
      @(negedge clk);
      check("li_wbv_off", wb_valid1, 1'b0);
      check("li_ready2", ready1, 1'b1);
   endtask

   task automatic do_alu1(input logic [2:0] op, input logic [1:0] rd,
                          input logic [1:0] rs1, input logic [1:0] rs2,
                          input logic [3:0] exp);
      check("alu_ready", ready1, 1'b1);
      valid1 = 1'b1;
      instr1 = ai(op, rd, rs1, rs2);
      @(posedge clk);
      @(negedge clk);
      valid1 = 1'b0;
      check("alu_exec_wbv", wb_valid1, 1'b0);
      check("alu_exec_busy", ready1, 1'b0);
      check("alu_op_out", alu_op1, op);
      @(negedge clk);
      check("alu_wbv", wb_valid1, 1'b1);
      check("alu_wbrd", wb_rd1, rd);
      check("alu_wbdata", wb_data1, exp);
      @(negedge clk);
      check("alu_wbv_off", wb_valid1, 1'b0);
      check("alu_ready2", ready1, 1'b1);
   endtask

   task automatic do_ill1(input logic [2:0] op);
      valid1 = 1'b1;
      instr1 = ai(op, 2'd0, 2'd1, 2'd2);
      @(posedge clk);
      @(negedge clk);
      valid1 = 1'b0;
      check("ill_pulse", illegal1, 1'b1);
      check("ill_wbv", wb_valid1, 1'b0);
      check("ill_ready", ready1, 1'b1);
      @(negedge clk);
      check("ill_off", illegal1, 1'b0);
      check("ill_wbv2", wb_valid1, 1'b0);
   endtask

   logic [11:0] prog3 [4];
   int          acc [4];
   int          idx, low_cnt, exec_cnt, exec_bad, wb_seen;
   logic        take;
   logic [3:0]  wbq [$];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      check("rst_ready", ready1, 1'b1);
      check("rst_alu_a", alu_a1, 4'd0);
      check("rst_alu_b", alu_b1, 4'd0);
      check("rst_alu_op", alu_op1, 3'd0);
      check("rst_wbv", wb_valid1, 1'b0);
      check("rst_wbrd", wb_rd1, 2'd0);
      check("rst_wbdata", wb_data1, 4'd0);
      check("rst_illegal", illegal1, 1'b0);
      for (int i = 0; i < 4; i++) rf1(2'(i), 4'd0);
      rst_n1 = 1'b1;
      rst_n3 = 1'b1;
      @(negedge clk);

      do_li1(2'd1, 4'b0010);
      do_li1(2'd2, 4'b0101);
      do_alu1(3'd0, 2'd3, 2'd1, 2'd2, 4'b0111);
      rf1(2'd3, 4'b0111);

      do_alu1(3'd1, 2'd0, 2'd1, 2'd2, 4'b1101);
      rf1(2'd0, 4'b1101);
      rf1(2'd1, 4'b0010);
      rf1(2'd2, 4'b0101);

      do_li1(2'd1, 4'b1100);
      do_li1(2'd2, 4'b1010);
      do_alu1(3'd2, 2'd0, 2'd1, 2'd2, 4'b1000);
      do_alu1(3'd3, 2'd0, 2'd1, 2'd2, 4'b1110);
      do_alu1(3'd4, 2'd0, 2'd1, 2'd2, 4'b0110);

      do_ill1(3'b101);
      do_ill1(3'b111);
      rf1(2'd0, 4'b0110);
      rf1(2'd1, 4'b1100);
      rf1(2'd2, 4'b1010);
      rf1(2'd3, 4'b0111);

      // rd==rs1 uses old r1; next instr sees the new r1
      do_alu1(3'd0, 2'd1, 2'd1, 2'd2, 4'b0110);
      do_alu1(3'd0, 2'd2, 2'd1, 2'd1, 4'b1100);
      rf1(2'd2, 4'b1100);

      // ALU_LAT=3, valid held high
      prog3[0] = li(2'd1, 4'd3);
      prog3[1] = li(2'd2, 4'd4);
      prog3[2] = ai(3'd0, 2'd3, 2'd1, 2'd2);
      prog3[3] = ai(3'd0, 2'd0, 2'd3, 2'd1);
      idx = 0; low_cnt = 0; exec_cnt = 0; exec_bad = 0;
      for (int i = 0; i < 4; i++) acc[i] = 0;
      valid3 = 1'b1;
      instr3 = prog3[0];
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (wb_valid3) wbq.push_back(wb_data3);
         if (idx == 3 && !ready3) low_cnt++;
         if (idx == 3 && !ready3 && !wb_valid3) begin
            exec_cnt++;
            if (alu_a3 !== 4'd3 || alu_b3 !== 4'd4 || alu_op3 !== 3'd0)
               exec_bad++;
         end
         take = ready3 && valid3;
         if (take) acc[idx] = cyc;
         @(posedge clk);
         #1;
         if (take) begin
            idx++;
            if (idx < 4) instr3 = prog3[idx];
            else valid3 = 1'b0;
         end
         @(negedge clk);
      end
      check("l3_accepts", idx, 4);
      check("l3_li_gap0", acc[1] - acc[0], 2);
      check("l3_li_gap1", acc[2] - acc[1], 2);
      check("l3_add_gap", acc[3] - acc[2], 5);
      check("l3_ready_low", low_cnt, 4);
      check("l3_exec_cycles", exec_cnt, 3);
      check("l3_exec_stable", exec_bad, 0);
      check("l3_wb_count", wbq.size(), 4);
      if (wbq.size() == 4) begin
         check("l3_wb0", wbq[0], 4'd3);
         check("l3_wb1", wbq[1], 4'd4);
         check("l3_wb2", wbq[2], 4'd7);
         check("l3_wb3", wbq[3], 4'hA);
      end
      rf3(2'd0, 4'hA);

      // reset on second EXEC cycle drops the writeback
      valid3 = 1'b1;
      instr3 = ai(3'd1, 2'd0, 2'd1, 2'd2);
      @(posedge clk);
      @(negedge clk);
      valid3 = 1'b0;
      check("r3_exec1", ready3, 1'b0);
      @(negedge clk);
      check("r3_exec2", ready3, 1'b0);
      rst_n3 = 1'b0;
      #1;
      check("r3_alu_a", alu_a3, 4'd0);
      check("r3_alu_b", alu_b3, 4'd0);
      check("r3_alu_op", alu_op3, 3'd0);
      check("r3_wbv", wb_valid3, 1'b0);
      check("r3_wbrd", wb_rd3, 2'd0);
      check("r3_wbdata", wb_data3, 4'd0);
      check("r3_illegal", illegal3, 1'b0);
      for (int i = 0; i < 4; i++) rf3(2'(i), 4'd0);
      @(negedge clk);
      rst_n3 = 1'b1;
      wb_seen = 0;
      low_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (wb_valid3) wb_seen++;
         if (!ready3) low_cnt++;
      end
      check("r3_no_wb", wb_seen, 0);
      check("r3_ready", low_cnt, 0);
      rf3(2'd0, 4'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
